// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input and instruction-memory write port.
// The loader is the slave: it sinks the stream and drives the write port.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills the instruction memory from a byte stream, then
// releases the core. Define IMEM_BOOT_CHECKSUM_EN for the trailer checksum.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    imem_boot_loader_if.slave bus,
    input  logic [63:0]       pc,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_fault,
    output logic              core_stall,
    output logic              load_done,
    output logic              load_error
);

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RUN
    } state_t;
`endif

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [DATA_W-9:0]   asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rdy_q, rdy_d;
    logic                stall_q, stall_d;
    logic                done_q, done_d;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                trl_q, trl_d;
    logic                err_q, err_d;
`endif

    logic [ADDR_W:0]     cnt_sat;
    logic                accept;
    logic                last;
    logic [DATA_W-1:0]   word;
    logic                unused_pc;

    assign cnt_sat = (word_count > MAX_CNT) ? MAX_CNT : word_count;
    assign accept  = rdy_q & bus.in_valid & ~start;
    assign last    = ({1'b0, widx_q} == (cnt_q - 1'b1));
    assign word    = {bus.in_byte, asm_q};

    // Next-state, counter and write-port computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d   = sum_q;
        trl_d   = trl_q;
`endif
        if (start) begin
            cnt_d  = cnt_sat;
            widx_d = '0;
            bidx_d = '0;
            asm_d  = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_d   = '0;
            trl_d   = (cnt_sat == '0);
            state_d = S_LOAD;
`else
            state_d = (cnt_sat == '0) ? S_RUN : S_LOAD;
`endif
        end else begin
            case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (accept) begin
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q != 2'd3) begin
                            asm_d[{bidx_q, 3'b000} +: 8] = bus.in_byte;
                        end else begin
                            asm_d = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                            if (trl_q) begin
                                trl_d   = 1'b0;
                                state_d = (word == sum_q) ? S_DRAIN : S_ERR;
                            end else begin
                                we_d    = 1'b1;
                                waddr_d = widx_q;
                                wdata_d = word;
                                widx_d  = widx_q + 1'b1;
                                sum_d   = sum_q + word;
                                if (last) begin
                                    trl_d = 1'b1;
                                end
                            end
`else
                            we_d    = 1'b1;
                            waddr_d = widx_q;
                            wdata_d = word;
                            widx_d  = widx_q + 1'b1;
                            if (last) begin
                                state_d = S_DRAIN;
                            end
`endif
                        end
                    end
                end
                S_DRAIN: state_d = S_RUN;
                S_RUN: ;
`ifdef IMEM_BOOT_CHECKSUM_EN
                S_ERR: ;
`endif
                default: state_d = S_IDLE;
            endcase
        end
        rdy_d   = (state_d == S_LOAD);
        stall_d = (state_d != S_RUN);
        done_d  = (state_d == S_RUN);
`ifdef IMEM_BOOT_CHECKSUM_EN
        err_d   = (state_d == S_ERR);
`endif
    end

    // Single register bank for the FSM, counters and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            stall_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q   <= '0;
            trl_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            stall_q <= stall_d;
            done_q  <= done_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
            trl_q   <= trl_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign core_stall    = stall_q;
    assign load_done     = done_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign load_error    = err_q;
`else
    assign load_error    = 1'b0;
`endif

    // Fetch index is the word part of the byte PC; faults only matter in RUN.
    assign fetch_addr  = pc[ADDR_W+1:2];
    assign fetch_fault = done_q & (pc[1:0] != 2'b00);
    assign unused_pc   = ^pc[63:ADDR_W+2];

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed sequence with a write scoreboard.
// Checksum steps are included when IMEM_BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic [63:0]   pc = '0;
    logic [AW-1:0] fetch_addr;
    logic          fetch_fault;
    logic          core_stall;
    logic          load_done;
    logic          load_error;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();

    imem_boot_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .word_count  (word_count),
        .bus         (bus),
        .pc          (pc),
        .fetch_addr  (fetch_addr),
        .fetch_fault (fetch_fault),
        .core_stall  (core_stall),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wq[$];
    wr_t         mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          n_push = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            n_wr++;
            chk("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", bus.mem_waddr, mon_e.a);
                chk("wr_data", bus.mem_wdata, mon_e.d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [AW:0] c);
        start = 1'b1;
        word_count = c;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clock);
        end
        bus.in_byte = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", n < 20, 1);
        @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap);
        end
    endtask

    // Loads wq; the trailer (checksum build only) is sum + tadj.
    task automatic do_load(input bit gap, input logic [31:0] tadj);
        logic [31:0] s;
        s = '0;
        foreach (wq[i]) begin
            exp_q.push_back({AW'(i), wq[i]});
            n_push++;
            s = s + wq[i];
        end
        foreach (wq[i]) begin
            send_word(wq[i], gap);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_word(s + tadj, gap);
`else
        if (tadj != 0) s = s + tadj;
`endif
        bus.in_valid = 1'b0;
    endtask

    // Called on the cycle after the last accepted byte (DRAIN).
    task automatic expect_run();
        chk("drain_stall", core_stall, 1);
        chk("drain_ready", bus.in_ready, 0);
        @(negedge clock);
        chk("run_stall", core_stall, 0);
        chk("run_done", load_done, 1);
        chk("run_error", load_error, 0);
    endtask

    initial begin
        bus.in_byte = '0;
        bus.in_valid = 1'b0;
        pc = 64'h6;
        repeat (2) @(negedge clock);

        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_waddr", bus.mem_waddr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_stall", core_stall, 1);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        chk("rst_fault", fetch_fault, 0);

        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte = 8'h77;
        repeat (2) @(negedge clock);
        bus.in_valid = 1'b0;
        chk("idle_stall", core_stall, 1);
        chk("idle_ready", bus.in_ready, 0);

        // Two-word back-to-back load.
        pulse_start(2);
        chk("load_ready", bus.in_ready, 1);
        chk("load_stall", core_stall, 1);
        wq = '{32'h0010_0113, 32'h0020_0093};
        do_load(1'b0, 32'h0);
        expect_run();

        // Fetch address translation in RUN.
        pc = 64'h8;
        #1;
        chk("fetch_addr_8", fetch_addr, 2);
        chk("fetch_fault_8", fetch_fault, 0);
        pc = 64'h6;
        #1;
        chk("fetch_addr_6", fetch_addr, 1);
        chk("fetch_fault_6", fetch_fault, 1);
        pc = 64'h0000_0001_0000_03FC;
        #1;
        chk("fetch_addr_top", fetch_addr, 8'hFF);
        chk("fetch_fault_top", fetch_fault, 0);
        pc = 64'h6;
        @(negedge clock);

        // Restart from RUN with a gapped single-word stream.
        pulse_start(1);
        chk("restart_stall", core_stall, 1);
        chk("restart_done", load_done, 0);
        chk("load_fault", fetch_fault, 0);
        wq = '{32'hDEAD_BEEF};
        do_load(1'b1, 32'h0);
        expect_run();

        // Abort mid-word; the start-coincident byte must be dropped.
        pulse_start(2);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        start = 1'b1;
        word_count = 1;
        bus.in_byte = 8'hAA;
        @(negedge clock);
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_ready", bus.in_ready, 1);
        wq = '{32'h1122_3344};
        do_load(1'b0, 32'h0);
        expect_run();

        // Reset in the middle of a load.
        pulse_start(3);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mrst_we", bus.mem_we, 0);
        chk("mrst_stall", core_stall, 1);
        chk("mrst_ready", bus.in_ready, 0);
        chk("mrst_done", load_done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("mrst_idle_stall", core_stall, 1);
        chk("mrst_idle_ready", bus.in_ready, 0);

        // Zero-count start.
        pulse_start(0);
`ifdef IMEM_BOOT_CHECKSUM_EN
        chk("zero_ready", bus.in_ready, 1);
        wq.delete();
        do_load(1'b0, 32'h0);
        expect_run();
`else
        chk("zero_done", load_done, 1);
        chk("zero_stall", core_stall, 0);
        chk("zero_ready", bus.in_ready, 0);
`endif

        // Restart from RUN reloads from address 0.
        pulse_start(1);
        chk("reload_stall", core_stall, 1);
        wq = '{32'hCAFE_F00D};
        do_load(1'b0, 32'h0);
        expect_run();

        // Oversized count saturates to the full memory depth.
        pulse_start(9'h1FF);
        wq.delete();
        for (int i = 0; i < 256; i++) begin
            wq.push_back(32'h1000_0000 + 32'(i) * 32'h0101_0003);
        end
        do_load(1'b0, 32'h0);
        expect_run();

`ifdef IMEM_BOOT_CHECKSUM_EN
        pulse_start(2);
        wq = '{32'h1, 32'h2};
        do_load(1'b0, 32'h0);
        expect_run();

        pulse_start(2);
        wq = '{32'h1, 32'h2};
        do_load(1'b0, 32'h1);
        chk("err_flag", load_error, 1);
        chk("err_stall", core_stall, 1);
        chk("err_ready", bus.in_ready, 0);
        @(negedge clock);
        chk("err_hold", load_error, 1);
        chk("err_hold_stall", core_stall, 1);

        pulse_start(2);
        chk("err_clear", load_error, 0);
        chk("err_reload", bus.in_ready, 1);
        do_load(1'b0, 32'h0);
        expect_run();
`endif

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("write_count", n_wr, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
